cdb_arbiter: RTL

Writeback arbiter that shares one common data bus (CDB) between the ALU result path and the LSB load-result path. Each source feeds a small FIFO. One result per cycle is granted round-robin and broadcast on a registered bus to the ROB, the reservation station and the LSB. Buffered results are flushed when the ROB raises `clr` on a mispredict.

---
 rtl/cdb_arbiter_pkg.sv | 23 ++
 rtl/cdb_arbiter_fifo.sv | 58 +++++
 rtl/cdb_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: ROB tag, data and address types, source encoding and FIFO payloads.
package cdb_arbiter_pkg;

  typedef logic [5:0]  ROB_WRAP_POS_TYPE;
  typedef logic [31:0] DATA_TYPE;
  typedef logic [31:0] ADDR_TYPE;

  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_LSB = 1'b1;

  typedef struct packed {
    ROB_WRAP_POS_TYPE rob_pos;
    DATA_TYPE         val;
    logic             jump;
    ADDR_TYPE         pc;
  } alu_entry_t;

  typedef struct packed {
    ROB_WRAP_POS_TYPE rob_pos;
    DATA_TYPE         val;
  } lsb_entry_t;

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// Circular result buffer for one CDB source: push, pop, head data, count and
// a look-ahead full flag computed from this cycle's push/pop.
module cdb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [PTR_W:0]   count,
  output logic             next_full
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W+1:0] FULL_SUM = (PTR_W+2)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic             full, push_eff, pop_eff;
  logic [PTR_W+1:0] next_count;

  assign full     = (count == FULL_CNT);
  // a push into a full buffer is dropped rather than overwriting the head
  assign push_eff = push && rdy && !clr && !rst && !full;
  assign pop_eff  = pop && rdy && !clr && !rst && (count != '0);
  assign dout     = mem[head];

  always_comb begin
    next_count = {1'b0, count} + (PTR_W+2)'(push_eff) - (PTR_W+2)'(pop_eff);
    next_full  = !rst && !clr && (next_count == FULL_SUM);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (push_eff) tail <= tail + 1'b1;
      if (pop_eff)  head <= head + 1'b1;
      count <= count + (PTR_W+1)'(push_eff) - (PTR_W+1)'(pop_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem[tail] <= din;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(push && rdy && !clr && full));

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin writeback arbiter for the ALU and LSB result paths onto one registered CDB.
// Optional CDB_BYPASS_EN: an entry arriving at an empty buffer may be granted in its arrival cycle.
//
// last_grant | meaning
// -----------+------------------------------------------------
// ALU (0)    | ALU won the last grant; LSB wins the next tie
// LSB (1)    | LSB won the last grant (reset value); ALU wins the next tie
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  parameter int PTR_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clr,
  input  logic             alu_valid,
  input  ROB_WRAP_POS_TYPE alu_rob_pos,
  input  DATA_TYPE         alu_val,
  input  logic             alu_jump,
  input  ADDR_TYPE         alu_pc,
  input  logic             lsb_valid,
  input  ROB_WRAP_POS_TYPE lsb_rob_pos,
  input  DATA_TYPE         lsb_val,
  output logic             alu_buf_next_full,
  output logic             lsb_buf_next_full,
  output logic             cdb_valid,
  output logic             cdb_src,
  output ROB_WRAP_POS_TYPE cdb_rob_pos,
  output DATA_TYPE         cdb_val,
  output logic             cdb_jump,
  output ADDR_TYPE         cdb_pc
);

  alu_entry_t     alu_in, alu_head, alu_sel;
  lsb_entry_t     lsb_in, lsb_head, lsb_sel;
  logic [PTR_W:0] alu_count, lsb_count;
  logic           alu_avail, lsb_avail, alu_grant, lsb_grant;
  logic           alu_bypass, lsb_bypass, last_grant;

  assign alu_in = '{rob_pos: alu_rob_pos, val: alu_val, jump: alu_jump, pc: alu_pc};
  assign lsb_in = '{rob_pos: lsb_rob_pos, val: lsb_val};

  always_comb begin
    alu_avail  = (alu_count != '0);
    lsb_avail  = (lsb_count != '0);
`ifdef CDB_BYPASS_EN
    alu_avail  = alu_avail || alu_valid;
    lsb_avail  = lsb_avail || lsb_valid;
`endif
    alu_grant  = alu_avail && (!lsb_avail || last_grant == CDB_SRC_LSB);
    lsb_grant  = lsb_avail && (!alu_avail || last_grant == CDB_SRC_ALU);
    alu_bypass = 1'b0;
    lsb_bypass = 1'b0;
`ifdef CDB_BYPASS_EN
    alu_bypass = alu_grant && (alu_count == '0);
    lsb_bypass = lsb_grant && (lsb_count == '0);
`endif
    alu_sel    = alu_bypass ? alu_in : alu_head;
    lsb_sel    = lsb_bypass ? lsb_in : lsb_head;
  end

  cdb_fifo #(.W($bits(alu_entry_t)), .DEPTH(BUF_DEPTH), .PTR_W(PTR_W)) u_alu_fifo (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .clr       (clr),
    .push      (alu_valid && !alu_bypass),
    .pop       (alu_grant && !alu_bypass),
    .din       (alu_in),
    .dout      (alu_head),
    .count     (alu_count),
    .next_full (alu_buf_next_full)
  );

  cdb_fifo #(.W($bits(lsb_entry_t)), .DEPTH(BUF_DEPTH), .PTR_W(PTR_W)) u_lsb_fifo (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .clr       (clr),
    .push      (lsb_valid && !lsb_bypass),
    .pop       (lsb_grant && !lsb_bypass),
    .din       (lsb_in),
    .dout      (lsb_head),
    .count     (lsb_count),
    .next_full (lsb_buf_next_full)
  );

  // payload fields hold on idle cycles; only cdb_valid drops
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid   <= 1'b0;
      cdb_src     <= 1'b0;
      cdb_rob_pos <= '0;
      cdb_val     <= '0;
      cdb_jump    <= 1'b0;
      cdb_pc      <= '0;
      last_grant  <= CDB_SRC_LSB;
    end else if (clr) begin
      cdb_valid <= 1'b0;
    end else if (rdy) begin
      cdb_valid <= alu_grant || lsb_grant;
      if (alu_grant) begin
        cdb_src     <= CDB_SRC_ALU;
        cdb_rob_pos <= alu_sel.rob_pos;
        cdb_val     <= alu_sel.val;
        cdb_jump    <= alu_sel.jump;
        cdb_pc      <= alu_sel.pc;
        last_grant  <= CDB_SRC_ALU;
      end else if (lsb_grant) begin
        cdb_src     <= CDB_SRC_LSB;
        cdb_rob_pos <= lsb_sel.rob_pos;
        cdb_val     <= lsb_sel.val;
        cdb_jump    <= 1'b0;
        cdb_pc      <= '0;
        last_grant  <= CDB_SRC_LSB;
      end
    end
  end

endmodule
